// File: rtl/flag_branch_unit.sv
// flag_branch_unit
// Holds the architectural N/Z/V flags, updates them from the EX-stage
// opcode/result, resolves B/BR branches in ID against those flags and drives
// a registered one-cycle redirect to fetch. Freezes itself once HLT executes.
// Optional feature macro: FLAG_FWD_EN -- when defined, a conditional branch in
// ID sees the flags being written by EX this cycle and never stalls; when
// undefined, such a branch stalls one cycle and uses the registered flags.
module flag_branch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [3:0]  ex_opcode,
   input  logic [15:0] ex_result,
   input  logic        ex_ovfl,
   input  logic        id_valid,
   input  logic [3:0]  id_opcode,
   input  logic [2:0]  id_ccc,
   input  logic [8:0]  id_imm9,
   input  logic [15:0] id_rs_val,
   input  logic [15:0] id_pc_plus2,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flag_v,
   output logic        stall,
   output logic        redirect_valid,
   output logic [15:0] redirect_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_REDIRECT,
      ST_HALTED
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;
   localparam logic [3:0] OP_HLT = 4'b1111;

   state_t      state;
   logic        set_nzv;
   logic        set_z_only;
   logic        nxt_n;
   logic        nxt_z;
   logic        nxt_v;
   logic        eval_n;
   logic        eval_z;
   logic        eval_v;
   logic        hlt_in_ex;
   logic        is_branch;
   logic        cond_true;
   logic        taken;
   logic [15:0] target;

   // Flag write-back decode, branch condition/target and stall generation.
   always_comb begin
      // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
      set_nzv    = ex_valid && (ex_opcode == OP_ADD || ex_opcode == OP_SUB);
      set_z_only = ex_valid && (ex_opcode == OP_XOR || ex_opcode == OP_SLL ||
                                ex_opcode == OP_SRA || ex_opcode == OP_ROR);
      nxt_n      = set_nzv ? ex_result[15] : flag_n;
      nxt_z      = (set_nzv || set_z_only) ? (ex_result == 16'h0000) : flag_z;
      nxt_v      = set_nzv ? ex_ovfl : flag_v;
      hlt_in_ex  = ex_valid && (ex_opcode == OP_HLT);
      is_branch  = id_valid && (id_opcode == OP_B || id_opcode == OP_BR);

`ifdef FLAG_FWD_EN
      // EX result bypassed straight into the branch condition.
      stall  = 1'b0;
      eval_n = nxt_n;
      eval_z = nxt_z;
      eval_v = nxt_v;
`else
      // A conditional branch behind a flag writer waits one cycle.
      stall  = (state == ST_RUN) && is_branch && (id_ccc != 3'b111) &&
               (set_nzv || set_z_only);
      eval_n = flag_n;
      eval_z = flag_z;
      eval_v = flag_v;
`endif

      unique case (id_ccc)
         3'b000:  cond_true = !eval_z;
         3'b001:  cond_true = eval_z;
         3'b010:  cond_true = !eval_z && !eval_n;
         3'b011:  cond_true = eval_n;
         3'b100:  cond_true = eval_z || !eval_n;
         3'b101:  cond_true = eval_n || eval_z;
         3'b110:  cond_true = eval_v;
         default: cond_true = 1'b1;
      endcase

      target = (id_opcode == OP_B)
             ? id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0}
             : id_rs_val;

      // HLT in EX beats any branch in ID; REDIRECT ignores its wrong-path slot.
      taken = (state == ST_RUN) && is_branch && !stall && cond_true && !hlt_in_ex;
   end

   // State machine with registered flags, redirect and halt outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state          <= ST_RUN;
         flag_n         <= 1'b0;
         flag_z         <= 1'b0;
         flag_v         <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 16'h0000;
         halted         <= 1'b0;
      end else begin
         unique case (state)
            ST_HALTED: begin
               redirect_valid <= 1'b0;
            end
            default: begin
               flag_n <= nxt_n;
               flag_z <= nxt_z;
               flag_v <= nxt_v;
               if (hlt_in_ex) begin
                  state          <= ST_HALTED;
                  halted         <= 1'b1;
                  redirect_valid <= 1'b0;
               end else if (taken) begin
                  state          <= ST_REDIRECT;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target;
               end else begin
                  state          <= ST_RUN;
                  redirect_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
